regfile_scoreboard: RTL and testbench

- Architectural register file (x0..x31) at the receiving end of the write-back interface. Consumes the WB stage's data/address/enable triple.
- Serves two combinational read ports to ID, with same-cycle write-to-read bypass.
- Tracks in-flight register writes with per-register pending counters. Issues a RAW hazard stall to ID.
- One instance per core.

---
 rtl/regfile_scoreboard.sv | 126 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-back bypass and a per-register
// pending-write scoreboard that raises a RAW hazard stall toward ID.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  wb_data_in,
    input  logic [4:0]       wb_addr_in,
    input  logic             wb_enable_in,
    input  logic [4:0]       rs1_addr_in,
    input  logic [4:0]       rs2_addr_in,
    input  logic             rs1_used_in,
    input  logic             rs2_used_in,
    output logic [XLEN-1:0]  rs1_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    input  logic             issue_valid_in,
    input  logic [4:0]       issue_rd_in,
    input  logic             issue_regwrite_in,
    input  logic             flush_in,
    output logic             hazard_stall_out,
    output logic             sb_error_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Register storage is flops rather than RAM: reset must clear every entry.
    logic [XLEN-1:0]             regs_reg [NREGS];
    logic [NREGS-1:0][CNT_W-1:0] cnt_reg;
    logic [NREGS-1:0][CNT_W-1:0] cnt_next;
    logic [NREGS-1:0]            err_hit;
    logic                        sb_error_reg;
    logic                        wb_write;
    logic [CNT_W-1:0]            rs1_cnt;
    logic [CNT_W-1:0]            rs2_cnt;
    logic                        pend1;
    logic                        pend2;

    assign wb_write = wb_enable_in & (wb_addr_in != 5'd0);

    // Register array update; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_write) begin
            regs_reg[wb_addr_in] <= wb_data_in;
        end
    end

    // Per-register next-count and overflow/underflow detection.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt_next[gi] = '0;
                assign err_hit[gi]  = 1'b0;
            end else begin : g_track
                logic inc;
                logic dec;
                logic at_max;
                logic at_zero;
                assign inc     = issue_valid_in & issue_regwrite_in & (issue_rd_in == 5'(gi));
                assign dec     = wb_enable_in & (wb_addr_in == 5'(gi));
                assign at_max  = (cnt_reg[gi] == CNT_MAX);
                assign at_zero = (cnt_reg[gi] == '0);
                // Simultaneous issue and write-back cancel; saturate at both ends.
                assign cnt_next[gi] = (inc & ~dec & ~at_max)  ? cnt_reg[gi] + CNT_ONE :
                                      (dec & ~inc & ~at_zero) ? cnt_reg[gi] - CNT_ONE :
                                                                cnt_reg[gi];
                assign err_hit[gi]  = (inc & ~dec & at_max) | (dec & ~inc & at_zero);
            end
        end
    endgenerate

    // Counter state and sticky error; flush clears counts and masks errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            sb_error_reg <= 1'b0;
        end else if (flush_in) begin
            cnt_reg      <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (|err_hit) begin
                sb_error_reg <= 1'b1;
            end
        end
    end

    // Combinational read ports with same-cycle write-back bypass.
    always_comb begin
        rs1_data_out = '0;
        rs2_data_out = '0;
        if (rs1_addr_in != 5'd0) begin
            if (wb_enable_in && (wb_addr_in == rs1_addr_in)) begin
                rs1_data_out = wb_data_in;
            end else begin
                rs1_data_out = regs_reg[rs1_addr_in];
            end
        end
        if (rs2_addr_in != 5'd0) begin
            if (wb_enable_in && (wb_addr_in == rs2_addr_in)) begin
                rs2_data_out = wb_data_in;
            end else begin
                rs2_data_out = regs_reg[rs2_addr_in];
            end
        end
    end

    // A lone outstanding write that completes this cycle is covered by bypass.
    assign rs1_cnt = cnt_reg[rs1_addr_in];
    assign rs2_cnt = cnt_reg[rs2_addr_in];
    assign pend1 = rs1_used_in & (rs1_addr_in != 5'd0) & (rs1_cnt != '0) &
                   ~((rs1_cnt == CNT_ONE) & wb_enable_in & (wb_addr_in == rs1_addr_in));
    assign pend2 = rs2_used_in & (rs2_addr_in != 5'd0) & (rs2_cnt != '0) &
                   ~((rs2_cnt == CNT_ONE) & wb_enable_in & (wb_addr_in == rs2_addr_in));

    assign hazard_stall_out = pend1 | pend2;
    assign sb_error_out     = sb_error_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios plus
// constrained-random traffic against an array/counter reference model.
module tb_regfile_scoreboard;

    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] wb_data_in;
    logic [4:0]      wb_addr_in;
    logic            wb_enable_in;
    logic [4:0]      rs1_addr_in;
    logic [4:0]      rs2_addr_in;
    logic            rs1_used_in;
    logic            rs2_used_in;
    logic [XLEN-1:0] rs1_data_out;
    logic [XLEN-1:0] rs2_data_out;
    logic            issue_valid_in;
    logic [4:0]      issue_rd_in;
    logic            issue_regwrite_in;
    logic            flush_in;
    logic            hazard_stall_out;
    logic            sb_error_out;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wb_data_in        (wb_data_in),
        .wb_addr_in        (wb_addr_in),
        .wb_enable_in      (wb_enable_in),
        .rs1_addr_in       (rs1_addr_in),
        .rs2_addr_in       (rs2_addr_in),
        .rs1_used_in       (rs1_used_in),
        .rs2_used_in       (rs2_used_in),
        .rs1_data_out      (rs1_data_out),
        .rs2_data_out      (rs2_data_out),
        .issue_valid_in    (issue_valid_in),
        .issue_rd_in       (issue_rd_in),
        .issue_regwrite_in (issue_regwrite_in),
        .flush_in          (flush_in),
        .hazard_stall_out  (hazard_stall_out),
        .sb_error_out      (sb_error_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     id;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            stall;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_tx     = 0;

    // Reference model: architectural values, outstanding-write counts, sticky error.
    logic [XLEN-1:0] m_regs [NREGS];
    int              m_cnt  [NREGS];
    bit              m_err;

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (wb_enable_in && wb_addr_in == a) return wb_data_in;
        return m_regs[a];
    endfunction

    function automatic bit m_pend(input logic [4:0] a, input logic used);
        if (!used || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
        if (m_cnt[a] == 1 && wb_enable_in && wb_addr_in == a) return 1'b0;
        return 1'b1;
    endfunction

    // Apply the clock edge to the model using the inputs held during that cycle.
    task automatic model_update();
        int ir;
        int dr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (wb_enable_in && wb_addr_in != 5'd0) m_regs[wb_addr_in] = wb_data_in;
        if (flush_in) begin
            for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
            return;
        end
        ir = (issue_valid_in && issue_regwrite_in) ? int'(issue_rd_in) : 0;
        dr = wb_enable_in ? int'(wb_addr_in) : 0;
        if (ir != dr) begin
            if (ir != 0) begin
                if (m_cnt[ir] == CNT_MAX) m_err = 1'b1;
                else m_cnt[ir]++;
            end
            if (dr != 0) begin
                if (m_cnt[dr] == 0) m_err = 1'b1;
                else m_cnt[dr]--;
            end
        end
    endtask

    task automatic idle();
        wb_data_in        = '0;
        wb_addr_in        = '0;
        wb_enable_in      = 1'b0;
        rs1_addr_in       = '0;
        rs2_addr_in       = '0;
        rs1_used_in       = 1'b0;
        rs2_used_in       = 1'b0;
        issue_valid_in    = 1'b0;
        issue_rd_in       = '0;
        issue_regwrite_in = 1'b0;
        flush_in          = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
        rs1_addr_in = a1; rs1_used_in = u1;
        rs2_addr_in = a2; rs2_used_in = u2;
    endtask

    task automatic wb(input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_enable_in = 1'b1; wb_addr_in = a; wb_data_in = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue_valid_in = 1'b1; issue_regwrite_in = 1'b1; issue_rd_in = a;
    endtask

    // Push the expected outputs for the current inputs, then advance one clock.
    task automatic cycle();
        exp_t e;
        e.id    = n_tx;
        e.rs1   = m_read(rs1_addr_in);
        e.rs2   = m_read(rs2_addr_in);
        e.stall = m_pend(rs1_addr_in, rs1_used_in) | m_pend(rs2_addr_in, rs2_used_in);
        e.err   = m_err;
        exp_q.push_back(e);
        n_tx++;
        @(posedge clk);
        model_update();
        #1;
        idle();
    endtask

    task automatic chk(input string name, input logic [31:0] id,
                       input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s tx=%0d actual=%h required=%h", name, id, act, req);
    endtask

    // Monitor: compares DUT outputs against queued expectations mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("tx %0d rs1=%h rs2=%h stall=%b err=%b",
                     e.id, rs1_data_out, rs2_data_out, hazard_stall_out, sb_error_out);
            chk("rs1_data", e.id, rs1_data_out, e.rs1);
            chk("rs2_data", e.id, rs2_data_out, e.rs2);
            chk("hazard_stall", e.id, XLEN'(hazard_stall_out), XLEN'(e.stall));
            chk("sb_error", e.id, XLEN'(sb_error_out), XLEN'(e.err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog tx=%0d actual=timeout required=finish", n_tx);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] r;
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cycle();                                  // outputs while held in reset
        rst_n = 1'b1;

        rd(5'd5, 1'b1, 5'd0, 1'b1); cycle();      // post-reset reads are zero

        iss(5'd5); cycle();
        wb(5'd5, 32'hDEADBEEF); rd(5'd5, 1'b1, 5'd0, 1'b0); cycle();  // bypass, hazard resolved
        rd(5'd5, 1'b1, 5'd5, 1'b0); cycle();      // committed value
        wb(5'd0, 32'h1234); rd(5'd0, 1'b1, 5'd0, 1'b1); cycle();      // x0 stays 0
        rd(5'd0, 1'b0, 5'd5, 1'b0); cycle();

        iss(5'd7); cycle();
        rd(5'd7, 1'b1, 5'd0, 1'b0); cycle();      // stall
        rd(5'd7, 1'b0, 5'd0, 1'b0); cycle();      // not consumed: no stall
        wb(5'd7, 32'hA5A5A5A5); rd(5'd7, 1'b1, 5'd0, 1'b0); cycle();
        rd(5'd7, 1'b1, 5'd7, 1'b1); cycle();      // count back to zero

        iss(5'd3); cycle();
        iss(5'd3); cycle();
        wb(5'd3, 32'h0000_0333); rd(5'd3, 1'b1, 5'd0, 1'b0); cycle();  // 2 outstanding: stall holds
        wb(5'd3, 32'h0000_0334); rd(5'd3, 1'b1, 5'd0, 1'b0); cycle();  // last one: stall drops
        rd(5'd0, 1'b0, 5'd3, 1'b1); cycle();

        iss(5'd9); cycle();
        iss(5'd9); wb(5'd9, 32'h99); rd(5'd0, 1'b0, 5'd9, 1'b1); cycle();
        rd(5'd0, 1'b0, 5'd9, 1'b1); cycle();      // count still 1
        wb(5'd9, 32'h9A); cycle();

        iss(5'd2); cycle();
        iss(5'd8); rd(5'd2, 1'b1, 5'd8, 1'b1); cycle();
        rd(5'd2, 1'b1, 5'd8, 1'b1); cycle();
        flush_in = 1'b1; wb(5'd8, 32'h55); rd(5'd2, 1'b1, 5'd8, 1'b1); cycle();
        rd(5'd8, 1'b1, 5'd2, 1'b1); cycle();      // flushed, x8 committed, no error

        // Random traffic that never over- or under-flows a counter.
        for (int n = 0; n < 400; n++) begin
            rd(5'($urandom_range(0, 31)), 1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                r = 5'($urandom_range(0, 31));
                if (m_cnt[r] == 0) r = 5'd0;
                if ($urandom_range(0, 3) == 0) r = rs1_addr_in;
                if (m_cnt[r] == 0) r = 5'd0;
                wb(r, $urandom);
            end
            if (!(m_pend(rs1_addr_in, rs1_used_in) | m_pend(rs2_addr_in, rs2_used_in))
                && $urandom_range(0, 1) == 1) begin
                issue_valid_in    = 1'b1;
                issue_rd_in       = 5'($urandom_range(0, 31));
                issue_regwrite_in = 1'($urandom_range(0, 3) != 0);
                if (m_cnt[issue_rd_in] == CNT_MAX) issue_regwrite_in = 1'b0;
            end
            flush_in = ($urandom_range(0, 24) == 0);
            cycle();
        end

        flush_in = 1'b1; cycle();
        for (int k = 0; k < 4; k++) begin         // 4th issue overflows
            iss(5'd4); rd(5'd4, 1'b1, 5'd0, 1'b0); cycle();
        end
        rd(5'd4, 1'b1, 5'd8, 1'b1); cycle();

        // Asynchronous reset between clock edges clears everything at once.
        rst_n = 1'b0;
        model_reset();
        rd(5'd8, 1'b1, 5'd4, 1'b1); cycle();
        rst_n = 1'b1;
        rd(5'd7, 1'b1, 5'd4, 1'b1); cycle();

        wb(5'd12, 32'hC0FFEE); rd(5'd12, 1'b1, 5'd0, 1'b0); cycle();   // underflow
        rd(5'd12, 1'b1, 5'd0, 1'b0); cycle();
        iss(5'd12); cycle();
        wb(5'd12, 32'h12); cycle();
        rd(5'd12, 1'b1, 5'd12, 1'b1); cycle();    // still sticky

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
